// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } hdu_state_t;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detect (in: EX load dest, ID sources; out: hz)
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                 memRead_ID_EX,
    input  logic [REG_IDX_W-1:0] rt_ID_EX,
    input  logic [REG_IDX_W-1:0] rs_IF_ID,
    input  logic [REG_IDX_W-1:0] rt_IF_ID,
    input  logic                 usesRt_IF_ID,
    output logic                 hz
);

    // $zero is never a real dependency, so a load targeting it never stalls.
    assign hz = memRead_ID_EX && (rt_ID_EX != REG_ZERO) &&
                ((rt_ID_EX == rs_IF_ID) || (usesRt_IF_ID && (rt_ID_EX == rt_IF_ID)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/freeze sequencer for the 5-stage pipeline; HDU_PERF_CNT_EN enables stallCount/flushCount
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int WAIT_TIMEOUT      = 64,
    parameter int CNT_W             = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 memRead_ID_EX,
    input  logic [REG_IDX_W-1:0] rt_ID_EX,
    input  logic [REG_IDX_W-1:0] rs_IF_ID,
    input  logic [REG_IDX_W-1:0] rt_IF_ID,
    input  logic                 usesRt_IF_ID,
    input  logic                 branchTaken,
    input  logic                 memBusy,
    output logic                 pcWr,
    output logic                 ifIdWr,
    output logic                 idExWr,
    output logic                 exMemWr,
    output logic                 memWbWr,
    output logic                 ctrlBubble,
    output logic                 ifIdFlush,
    output logic                 memTimeout,
    output logic [CNT_W-1:0]     stallCount,
    output logic [CNT_W-1:0]     flushCount
);

    localparam int STALL_W = $clog2(LOAD_STALL_CYCLES + 1);
    localparam int WAIT_W  = $clog2(WAIT_TIMEOUT + 1);

    hdu_state_t         state, next_state;
    logic [STALL_W-1:0] stall_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               hz;

    load_use_detect u_load_use_detect (
        .memRead_ID_EX (memRead_ID_EX),
        .rt_ID_EX      (rt_ID_EX),
        .rs_IF_ID      (rs_IF_ID),
        .rt_IF_ID      (rt_IF_ID),
        .usesRt_IF_ID  (usesRt_IF_ID),
        .hz            (hz)
    );

    // MEM_WAIT with memBusy low behaves exactly like RUN, so the hazard
    // terms are re-evaluated in the cycle the freeze lifts.
    always_comb begin
        pcWr       = 1'b1;
        ifIdWr     = 1'b1;
        idExWr     = 1'b1;
        exMemWr    = 1'b1;
        memWbWr    = 1'b1;
        ctrlBubble = 1'b0;
        ifIdFlush  = 1'b0;
        next_state = RUN;
        if (reset) begin
            pcWr    = 1'b0;
            ifIdWr  = 1'b0;
            idExWr  = 1'b0;
            exMemWr = 1'b0;
            memWbWr = 1'b0;
        end else if (memBusy) begin
            pcWr       = 1'b0;
            ifIdWr     = 1'b0;
            idExWr     = 1'b0;
            exMemWr    = 1'b0;
            memWbWr    = 1'b0;
            next_state = MEM_WAIT;
        end else if (branchTaken) begin
            // The branch is older than any stalled instruction: flush it and abort the stall.
            ctrlBubble = 1'b1;
            ifIdFlush  = 1'b1;
        end else if (hz || (state == LOAD_STALL)) begin
            pcWr       = 1'b0;
            ifIdWr     = 1'b0;
            ctrlBubble = 1'b1;
            if (state == LOAD_STALL) begin
                next_state = (stall_cnt == STALL_W'(1)) ? RUN : LOAD_STALL;
            end else begin
                next_state = (LOAD_STALL_CYCLES > 1) ? LOAD_STALL : RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            stall_cnt  <= '0;
            wait_cnt   <= '0;
            memTimeout <= 1'b0;
        end else begin
            state <= next_state;

            if (next_state == LOAD_STALL) begin
                stall_cnt <= (state == LOAD_STALL) ? stall_cnt - STALL_W'(1)
                                                   : STALL_W'(LOAD_STALL_CYCLES - 1);
            end

            // wait_cnt holds the number of frozen cycles already completed,
            // so the first freeze cycle (entered from RUN/LOAD_STALL) seeds it with 1.
            if (memBusy) begin
                if (state == MEM_WAIT) begin
                    if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                    if (wait_cnt == WAIT_W'(WAIT_TIMEOUT - 1)) begin
                        memTimeout <= 1'b1;
                    end
                end else begin
                    wait_cnt <= WAIT_W'(1);
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

`ifdef HDU_PERF_CNT_EN
    logic             stall_ev, flush_ev;
    logic [CNT_W-1:0] stall_q, flush_q;

    assign stall_ev = !reset && !memBusy && !branchTaken && (hz || (state == LOAD_STALL));
    assign flush_ev = !reset && !memBusy && branchTaken;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_ev && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_ev && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stallCount = stall_q;
    assign flushCount = flush_q;
`else
    assign stallCount = '0;
    assign flushCount = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized bench for pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;

    localparam int L    = 3;
    localparam int WT   = 64;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          memRead_ID_EX;
    logic [4:0]    rt_ID_EX, rs_IF_ID, rt_IF_ID;
    logic          usesRt_IF_ID, branchTaken, memBusy;
    logic          pcWr, ifIdWr, idExWr, exMemWr, memWbWr, ctrlBubble, ifIdFlush, memTimeout;
    logic [CW-1:0] stallCount, flushCount;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .LOAD_STALL_CYCLES (L),
        .WAIT_TIMEOUT      (WT),
        .CNT_W             (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .memRead_ID_EX (memRead_ID_EX),
        .rt_ID_EX      (rt_ID_EX),
        .rs_IF_ID      (rs_IF_ID),
        .rt_IF_ID      (rt_IF_ID),
        .usesRt_IF_ID  (usesRt_IF_ID),
        .branchTaken   (branchTaken),
        .memBusy       (memBusy),
        .pcWr          (pcWr),
        .ifIdWr        (ifIdWr),
        .idExWr        (idExWr),
        .exMemWr       (exMemWr),
        .memWbWr       (memWbWr),
        .ctrlBubble    (ctrlBubble),
        .ifIdFlush     (ifIdFlush),
        .memTimeout    (memTimeout),
        .stallCount    (stallCount),
        .flushCount    (flushCount)
    );

    int total = 0;
    int bad   = 0;

    // Model: bubbles still owed, length of the current memBusy run, sticky timeout, event counts.
    int rem      = 0;
    int busy_run = 0;
    bit tmo      = 0;
    int stalls   = 0;
    int flushes  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // One clock: drive, check Mealy outputs, advance model, check registered outputs.
    task automatic cycle(input bit r, input bit mr, input int rte, input int rs, input int rt,
                         input bit ur, input bit br, input bit bz);
        logic [6:0] e;
        bit         hzm;
        int         es, ef;
        @(negedge clk);
        reset         = r;
        memRead_ID_EX = mr;
        rt_ID_EX      = 5'(rte);
        rs_IF_ID      = 5'(rs);
        rt_IF_ID      = 5'(rt);
        usesRt_IF_ID  = ur;
        branchTaken   = br;
        memBusy       = bz;
        #1;
        hzm = mr && (rte != 0) && ((rte == rs) || (ur && (rte == rt)));
        // {pcWr, ifIdWr, idExWr, exMemWr, memWbWr, ctrlBubble, ifIdFlush}
        if (r)                  e = 7'b0000000;
        else if (bz)            e = 7'b0000000;
        else if (br)            e = 7'b1111111;
        else if (rem > 0 || hzm) e = 7'b0011110;
        else                    e = 7'b1111100;
        check("ctl", {pcWr, ifIdWr, idExWr, exMemWr, memWbWr, ctrlBubble, ifIdFlush}, e);

        if (r) begin
            rem = 0; busy_run = 0; tmo = 0; stalls = 0; flushes = 0;
        end else if (bz) begin
            busy_run++;
            if (busy_run >= WT) tmo = 1;
            rem = 0;
        end else begin
            busy_run = 0;
            if (br) begin
                rem = 0;
                flushes = sat_inc(flushes);
            end else if (rem > 0 || hzm) begin
                stalls = sat_inc(stalls);
                rem = (rem > 0) ? rem - 1 : L - 1;
            end
        end

        @(posedge clk);
        #1;
`ifdef HDU_PERF_CNT_EN
        es = stalls;
        ef = flushes;
`else
        es = 0;
        ef = 0;
`endif
        check("tmo", memTimeout, tmo);
        check("scnt", stallCount, es);
        check("fcnt", flushCount, ef);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; memRead_ID_EX = 0; rt_ID_EX = 0; rs_IF_ID = 0; rt_IF_ID = 0;
        usesRt_IF_ID = 0; branchTaken = 0; memBusy = 0;

        cycle(1, 1, 8, 8, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 1, 1);
        idle(2);

        // lw $t0 in EX, ID reads rs=$t0
        cycle(0, 1, 8, 8, 3, 0, 0, 0);
        idle(4);
        // rt hazard only when ID actually reads rt
        cycle(0, 1, 9, 2, 9, 0, 0, 0);
        cycle(0, 1, 9, 2, 9, 1, 0, 0);
        idle(4);
        // load into $zero never stalls
        cycle(0, 1, 0, 0, 0, 1, 0, 0);
        idle(1);
        // branch and hazard together: branch wins
        cycle(0, 1, 8, 8, 8, 1, 1, 0);
        idle(1);
        // branch during a multi-cycle stall aborts it
        cycle(0, 1, 5, 5, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        // memBusy for 3 cycles, releasing straight into a hazard
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 1, 7, 7, 0, 0, 0, 0);
        idle(3);
        // memBusy interrupting a load stall
        cycle(0, 1, 4, 4, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);
        // timeout: 63 busy cycles is not enough, 64 is
        for (int i = 0; i < WT - 1; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        for (int i = 0; i < WT; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);
        // reset in the 2nd stall cycle
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 8, 8, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
